// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ valid/ready producers
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_w_en,
    output logic [DW-1:0]            fifo_data_in,
    output logic                     grant_valid,
    output logic [$clog2(NREQ)-1:0]  grant_id
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(BURST) + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] gid_q, gid_d, ptr_q, ptr_d, sel, gid_nxt;
    logic [BW-1:0] cnt_q, cnt_d;
    logic cur_valid, busy;
    assign busy = (state_q == BUSY) && !rst;
    assign gid_nxt = (gid_q == IW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
    assign grant_valid = (state_q == BUSY);
    assign grant_id = grant_valid ? gid_q : '0;
    assign fifo_w_en = busy && cur_valid && !fifo_full;
    // round-robin pick: first valid requester at or above rr_ptr, wrapping; lowest offset wins
    always_comb begin
        sel = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--)
            for (int i = 0; i < NREQ; i++)
                if (i == (int'(ptr_q) + k) % NREQ && req_valid[i]) sel = IW'(i);
    end
    // mux the grantee's valid, data and ready onto the shared write port
    always_comb begin
        cur_valid = 1'b0;
        fifo_data_in = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            if (IW'(i) == gid_q) begin
                cur_valid = req_valid[i];
                fifo_data_in = req_data[i*DW +: DW];
                req_ready[i] = busy && !fifo_full;
            end
    end
    // next state: grant in IDLE, count beats in BUSY, release on burst end or dropped valid
    always_comb begin
        state_d = state_q;
        gid_d = gid_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (|req_valid) begin
                state_d = BUSY;
                gid_d = sel;
                cnt_d = '0;
            end
        end else if (!cur_valid) begin
            state_d = IDLE;
            ptr_d = gid_nxt;
        end else if (!fifo_full) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BW'(BURST - 1)) begin
                state_d = IDLE;
                ptr_d = gid_nxt;
            end
        end
    end
    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gid_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed per-cycle vectors for the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0] req_ready;
    logic fifo_full = 1'b0;
    logic fifo_w_en;
    logic [7:0] fifo_data_in;
    logic grant_valid;
    logic [1:0] grant_id;
    int checks = 0;
    int failures = 0;
    logic [7:0] base [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    // row = {rst, full, valid[3:0], exp_w_en, exp_grant_valid, exp_grant_id[1:0]}
    function automatic logic [9:0] mk(int r, int f, int v, int w, int g, int id);
        return {1'(r), 1'(f), 4'(v), 1'(w), 1'(g), 2'(id)};
    endfunction

    function automatic logic [14:0] expect_of(input logic [9:0] row);
        logic [3:0] rdy;
        logic [7:0] d;
        rdy = (row[2] && !row[8] && !row[9]) ? (4'b0001 << row[1:0]) : 4'b0000;
        d = row[3] ? base[row[1:0]] + 8'(cnt[row[1:0]]) : 8'h00;
        return {row[3], row[2], row[1:0], rdy, d};
    endfunction

    function automatic logic [14:0] observe();
        return {fifo_w_en, grant_valid, grant_id, req_ready, fifo_w_en ? fifo_data_in : 8'h00};
    endfunction

    task automatic apply(input logic [9:0] row);
        @(negedge clk);
        rst = row[9];
        fifo_full = row[8];
        req_valid = row[7:4];
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + 8'(cnt[i]);
        #1;
    endtask

    task automatic advance(input logic [9:0] row);
        if (row[3]) cnt[row[1:0]]++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
    endtask

    task automatic test_reset();
        logic [9:0] rows [$];
        @(posedge clk);
        rows.push_back(mk(1, 0, 'b0000, 0, 0, 0));
        rows.push_back(mk(1, 0, 'b0000, 0, 0, 0));
        rows.push_back(mk(1, 0, 'b1111, 0, 0, 0));
        rows.push_back(mk(0, 0, 'b0000, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            checks++;
            if (observe() !== expect_of(rows[i])) begin
                failures++;
                $display("FAIL reset row %0d: got %h expected %h", i, observe(), expect_of(rows[i]));
            end
            advance(rows[i]);
        end
    endtask

    task automatic test_single();
        logic [9:0] rows [$];
        clear_counts();
        base[2] = 8'hA0;
        rows.push_back(mk(0, 0, 'b0100, 0, 0, 0));
        repeat (4) rows.push_back(mk(0, 0, 'b0100, 1, 1, 2));
        rows.push_back(mk(0, 0, 'b0100, 0, 0, 0));
        repeat (2) rows.push_back(mk(0, 0, 'b0100, 1, 1, 2));
        rows.push_back(mk(0, 0, 'b0000, 0, 1, 2));
        rows.push_back(mk(0, 0, 'b0000, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            checks++;
            if (observe() !== expect_of(rows[i])) begin
                failures++;
                $display("FAIL single row %0d: got %h expected %h", i, observe(), expect_of(rows[i]));
            end
            advance(rows[i]);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] rows [$];
        clear_counts();
        base = '{8'h40, 8'h50, 8'h60, 8'h70};
        rows.push_back(mk(1, 0, 'b1111, 0, 0, 0));
        for (int b = 0; b < 5; b++) begin
            rows.push_back(mk(0, 0, 'b1111, 0, 0, 0));
            repeat (4) rows.push_back(mk(0, 0, 'b1111, 1, 1, b % 4));
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            checks++;
            if (observe() !== expect_of(rows[i])) begin
                failures++;
                $display("FAIL round_robin row %0d: got %h expected %h", i, observe(), expect_of(rows[i]));
            end
            advance(rows[i]);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] rows [$];
        clear_counts();
        base[1] = 8'hB0;
        rows.push_back(mk(0, 0, 'b0010, 0, 0, 0));
        repeat (2) rows.push_back(mk(0, 0, 'b0010, 1, 1, 1));
        repeat (3) rows.push_back(mk(0, 1, 'b0010, 0, 1, 1));
        repeat (2) rows.push_back(mk(0, 0, 'b0010, 1, 1, 1));
        rows.push_back(mk(0, 0, 'b0000, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            checks++;
            if (observe() !== expect_of(rows[i])) begin
                failures++;
                $display("FAIL backpressure row %0d: got %h expected %h", i, observe(), expect_of(rows[i]));
            end
            advance(rows[i]);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] rows [$];
        clear_counts();
        base[1] = 8'hD0;
        base[2] = 8'hC0;
        rows.push_back(mk(0, 0, 'b0100, 0, 0, 0));
        repeat (2) rows.push_back(mk(0, 0, 'b0100, 1, 1, 2));
        rows.push_back(mk(1, 0, 'b0100, 0, 1, 2));
        rows.push_back(mk(0, 0, 'b1110, 0, 0, 0));
        rows.push_back(mk(0, 0, 'b1110, 1, 1, 1));
        rows.push_back(mk(0, 0, 'b0000, 0, 1, 1));
        rows.push_back(mk(0, 0, 'b0000, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            checks++;
            if (observe() !== expect_of(rows[i])) begin
                failures++;
                $display("FAIL reset_mid row %0d: got %h expected %h", i, observe(), expect_of(rows[i]));
            end
            advance(rows[i]);
        end
    endtask

    task automatic test_early_release();
        logic [9:0] rows [$];
        clear_counts();
        base[0] = 8'hE0;
        base[3] = 8'hF0;
        rows.push_back(mk(1, 0, 'b0000, 0, 0, 0));
        rows.push_back(mk(0, 0, 'b1001, 0, 0, 0));
        repeat (2) rows.push_back(mk(0, 0, 'b1001, 1, 1, 0));
        rows.push_back(mk(0, 0, 'b1000, 0, 1, 0));
        rows.push_back(mk(0, 0, 'b1000, 0, 0, 0));
        repeat (2) rows.push_back(mk(0, 0, 'b1000, 1, 1, 3));
        rows.push_back(mk(0, 1, 'b0000, 0, 1, 3));
        rows.push_back(mk(0, 0, 'b0000, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            checks++;
            if (observe() !== expect_of(rows[i])) begin
                failures++;
                $display("FAIL early_release row %0d: got %h expected %h", i, observe(), expect_of(rows[i]));
            end
            advance(rows[i]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        test_early_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
